// File: rtl/sprite_stream_reader.sv
// Streams one sprite from a 1-cycle-read sprite RAM as row-major pixels over valid/ready, via a small output FIFO.
// Optional horizontal flip: define SPRITE_READER_MIRROR_EN to add the mirror port.
module sprite_stream_reader #(
  parameter int SPRITE_W   = 32,
  parameter int SPRITE_H   = 32,
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 9,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic [ADDR_W-1:0]           mem_addr,
  input  logic [DATA_W-1:0]           mem_data,
  output logic [DATA_W-1:0]           pix_data,
  output logic [$clog2(SPRITE_W)-1:0] pix_x,
  output logic [$clog2(SPRITE_H)-1:0] pix_y,
  output logic                        pix_valid,
  input  logic                        pix_ready
`ifdef SPRITE_READER_MIRROR_EN
  ,input logic                        mirror
`endif
);

  localparam int XW = $clog2(SPRITE_W);
  localparam int YW = $clog2(SPRITE_H);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
  } pix_t;

  logic [1:0]    state;
  logic [XW-1:0] x_q, tag_x, col;
  logic [YW-1:0] y_q, tag_y;
  logic          inflight;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [CW:0]   occ;
  logic          pop, push, issue, last;
  pix_t          fifo_q [FIFO_DEPTH];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign pix_valid = (count != '0);
  assign pop       = pix_valid & pix_ready;
  assign push      = inflight;
  assign busy      = (state != S_IDLE);
  assign pix_data  = fifo_q[rd_ptr].data;
  assign pix_x     = fifo_q[rd_ptr].x;
  assign pix_y     = fifo_q[rd_ptr].y;

  // A read is only issued if its data is guaranteed a FIFO slot when it lands next cycle.
  assign occ   = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
  assign issue = (state == S_RUN) && (occ < (CW+1)'(FIFO_DEPTH));
  assign last  = (x_q == XW'(SPRITE_W - 1)) && (y_q == YW'(SPRITE_H - 1));

`ifdef SPRITE_READER_MIRROR_EN
  logic mirror_q;
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                        mirror_q <= 1'b0;
    else if (state == S_IDLE && start) mirror_q <= mirror;
  end
  // SPRITE_W is a power of 2, so SPRITE_W-1-x is just the bitwise complement.
  assign col = mirror_q ? ~x_q : x_q;
`else
  assign col = x_q;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= S_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      tag_x    <= '0;
      tag_y    <= '0;
      mem_addr <= '0;
      inflight <= 1'b0;
      done     <= 1'b0;
    end else begin
      done     <= 1'b0;
      inflight <= issue;
      case (state)
        S_IDLE: if (start) begin
          state <= S_RUN;
          x_q   <= '0;
          y_q   <= '0;
        end
        S_RUN: if (issue) begin
          mem_addr <= {y_q, col};
          tag_x    <= x_q;
          tag_y    <= y_q;
          x_q      <= x_q + 1'b1;
          if (x_q == XW'(SPRITE_W - 1)) y_q <= y_q + 1'b1;
          if (last) state <= S_DRAIN;
        end
        S_DRAIN: if (count == '0 && !inflight) begin
          state <= S_IDLE;
          done  <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr] <= {mem_data, tag_x, tag_y};
        wr_ptr         <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

endmodule

// File: tb/tb_sprite_stream_reader.sv
// Directed bench for sprite_stream_reader: RAM preloaded with mem[i]=i, beat monitor checks order/data/stalls.
module tb_sprite_stream_reader;

  logic       CLK = 1'b0;
  logic       RST_N, start, pix_ready;
  logic       busy, done, pix_valid;
  logic [9:0] mem_addr;
  logic [8:0] mem_data, pix_data;
  logic [4:0] pix_x, pix_y;
  logic [8:0] ram [1024];
`ifdef SPRITE_READER_MIRROR_EN
  logic       mirror;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 CLK = ~CLK;

  // The RAM's address register is mem_addr itself: data is valid the cycle after issue.
  assign mem_data = ram[mem_addr];

  sprite_stream_reader dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .busy(busy), .done(done),
    .mem_addr(mem_addr), .mem_data(mem_data), .pix_data(pix_data),
    .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid), .pix_ready(pix_ready)
`ifdef SPRITE_READER_MIRROR_EN
    , .mirror(mirror)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Beat monitor: counters restart on every accepted start.
  int         beat_cnt = 0, bad_cnt = 0, stall_bad = 0, done_cnt = 0, done_busy = 0;
  logic       mir = 1'b0, hold_v = 1'b0;
  logic [8:0] hold_d = '0;
  logic [4:0] hold_x = '0, hold_y = '0;
  logic [4:0] ex, ey, ecol;
  logic [8:0] ed;
  assign ex   = beat_cnt[4:0];
  assign ey   = beat_cnt[9:5];
  assign ecol = mir ? 5'd31 - ex : ex;
  assign ed   = {ey[3:0], ecol};

  always @(negedge CLK) begin
    if (!RST_N) hold_v <= 1'b0;
    else if (start && !busy) begin
      beat_cnt  <= 0;
      bad_cnt   <= 0;
      stall_bad <= 0;
      done_cnt  <= 0;
      done_busy <= 0;
      hold_v    <= 1'b0;
`ifdef SPRITE_READER_MIRROR_EN
      mir       <= mirror;
`endif
    end else begin
      if (done) done_cnt <= done_cnt + 1;
      if (done && busy) done_busy <= done_busy + 1;
      if (hold_v && pix_valid && {pix_data, pix_x, pix_y} !== {hold_d, hold_x, hold_y})
        stall_bad <= stall_bad + 1;
      if (pix_valid && pix_ready) begin
        if (pix_data !== ed || pix_x !== ex || pix_y !== ey) bad_cnt <= bad_cnt + 1;
        beat_cnt <= beat_cnt + 1;
      end
      hold_v <= pix_valid && !pix_ready;
      hold_d <= pix_data;
      hold_x <= pix_x;
      hold_y <= pix_y;
    end
  end

  task automatic pulse_start();
    @(posedge CLK); #1 start = 1'b1;
    @(posedge CLK); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int maxc, input bit tog, input string tag);
    int c = 0;
    while (done_cnt == 0 && c < maxc) begin
      @(posedge CLK); #1;
      if (tog) pix_ready = ~pix_ready;
      c++;
    end
    chk({tag, "_done_seen"}, 32'(done_cnt != 0), 1);
  endtask

  task automatic wait_beats(input int n, input string tag);
    int c = 0;
    while (beat_cnt < n && c < 2000) begin
      @(posedge CLK); #1;
      c++;
    end
    chk({tag, "_reached"}, 32'(beat_cnt >= n), 1);
  endtask

  task automatic stream_ok(input string tag);
    chk({tag, "_beats"},    32'(beat_cnt), 1024);
    chk({tag, "_bad"},      32'(bad_cnt), 0);
    chk({tag, "_dones"},    32'(done_cnt), 1);
    chk({tag, "_donebusy"}, 32'(done_busy), 0);
    chk({tag, "_busy_end"}, 32'(busy), 0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 9'(i);
    RST_N = 1'b0; start = 1'b0; pix_ready = 1'b0;
`ifdef SPRITE_READER_MIRROR_EN
    mirror = 1'b0;
`endif
    #12;
    chk("rst_busy",  32'(busy), 0);
    chk("rst_done",  32'(done), 0);
    chk("rst_addr",  32'(mem_addr), 0);
    chk("rst_valid", 32'(pix_valid), 0);
    chk("rst_data",  32'(pix_data), 0);
    chk("rst_xy",    32'({pix_x, pix_y}), 0);
    @(negedge CLK); RST_N = 1'b1;

    // 1: full stream, ready high, first-pixel latency
    pix_ready = 1'b1;
    pulse_start();
    @(negedge CLK);
    chk("t1_busy",    32'(busy), 1);
    chk("t1_valid_t1", 32'(pix_valid), 0);
    @(negedge CLK);
    chk("t1_valid_t2", 32'(pix_valid), 0);
    chk("t1_addr0",   32'(mem_addr), 0);
    @(negedge CLK);
    chk("t1_valid_t3", 32'(pix_valid), 1);
    chk("t1_data0",   32'(pix_data), 0);
    chk("t1_addr1",   32'(mem_addr), 1);
    wait_done(3000, 1'b0, "t1");
    stream_ok("t1");
    chk("t1_done_1cyc", 32'(done), 0);

    // 2: ready toggling
    pix_ready = 1'b1;
    pulse_start();
    wait_done(5000, 1'b1, "t2");
    stream_ok("t2");
    chk("t2_stall", 32'(stall_bad), 0);

    // 3: long initial backpressure
    pix_ready = 1'b0;
    pulse_start();
    repeat (20) begin @(posedge CLK); #1; end
    chk("t3_addr_frz", 32'(mem_addr), 1);
    chk("t3_valid",    32'(pix_valid), 1);
    chk("t3_head",     32'(pix_data), 0);
    chk("t3_nobeat",   32'(beat_cnt), 0);
    pix_ready = 1'b1;
    repeat (2) begin @(posedge CLK); #1; end
    chk("t3_resume", 32'(beat_cnt), 2);
    wait_done(3000, 1'b0, "t3");
    stream_ok("t3");
    chk("t3_stall", 32'(stall_bad), 0);

    // 4: second start mid-stream is ignored
    pulse_start();
    wait_beats(100, "t4");
    start = 1'b1;
    @(posedge CLK); #1 start = 1'b0;
    chk("t4_busy", 32'(busy), 1);
    wait_done(3000, 1'b0, "t4");
    stream_ok("t4");

    // 5: async reset mid-stream
    pulse_start();
    wait_beats(500, "t5");
    #2 RST_N = 1'b0;
    #1;
    chk("t5_busy",  32'(busy), 0);
    chk("t5_valid", 32'(pix_valid), 0);
    chk("t5_addr",  32'(mem_addr), 0);
    chk("t5_data",  32'(pix_data), 0);
    chk("t5_xy",    32'({pix_x, pix_y}), 0);
    repeat (3) @(negedge CLK);
    chk("t5_nodone", 32'(done_cnt), 0);
    RST_N = 1'b1;
    pix_ready = 1'b0;
    pulse_start();
    repeat (2) begin @(posedge CLK); #1; end
    chk("t5_rs_valid", 32'(pix_valid), 1);
    chk("t5_rs_data",  32'(pix_data), 0);
    chk("t5_rs_xy",    32'({pix_x, pix_y}), 0);
    pix_ready = 1'b1;
    wait_done(3000, 1'b0, "t5");
    stream_ok("t5");

`ifdef SPRITE_READER_MIRROR_EN
    // 6: horizontal flip
    mirror = 1'b1;
    pix_ready = 1'b0;
    pulse_start();
    mirror = 1'b0;
    repeat (2) begin @(posedge CLK); #1; end
    chk("t6_data0", 32'(pix_data), 31);
    chk("t6_x0",    32'(pix_x), 0);
    pix_ready = 1'b1;
    wait_done(3000, 1'b0, "t6");
    stream_ok("t6");
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
